axi_dma_rd_if: RTL and testbench

AXI4 read-channel DMA master that turns one descriptor (base address, byte length) into a sequence of fixed-length read bursts. Returned beats are pushed into a downstream buffer interface. It sits beside the DMA write-side master on the shared DDR controller port. It uses the same bank/section/burst-index address packing, so a region written by the write side is read back with an identical descriptor.

---
 rtl/axi_dma_rd_if_if.sv | 36 +++
 rtl/axi_dma_rd_if.sv | 196 +++++++++++++++++++
 tb/tb_axi_dma_rd_if.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_dma_rd_if_if.sv
// ---------------------------------------------------------------------------
// axi_dma_rd_if_if
// AXI4 read-address and read-data channel bundle used by the DMA read master.
//   master modport : DMA side (drives AR, consumes R)
//   slave  modport : memory side (accepts AR, returns R)
// Signals: arid, araddr, arlen, arvalid, arready,
//          rid, rdata, rresp, rlast, rvalid, rready
// ---------------------------------------------------------------------------
interface axi_dma_rd_if_if #(
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int AXI_DATA_WIDTH  = 128,
    parameter int AXI_ID_WIDTH    = 1,
    parameter int AXI_BURST_WIDTH = 6
);
    logic [AXI_ID_WIDTH-1:0]    arid;
    logic [AXI_ADDR_WIDTH-1:0]  araddr;
    logic [AXI_BURST_WIDTH-1:0] arlen;
    logic                       arvalid;
    logic                       arready;
    logic [AXI_ID_WIDTH-1:0]    rid;
    logic [AXI_DATA_WIDTH-1:0]  rdata;
    logic [1:0]                 rresp;
    logic                       rlast;
    logic                       rvalid;
    logic                       rready;

    modport master (
        output arid, araddr, arlen, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_dma_rd_if.sv
// ---------------------------------------------------------------------------
// axi_dma_rd_if
// AXI4 read DMA master: one descriptor {bank, section, byte offset} + byte
// length becomes a series of fixed BURST_LEN-beat read bursts, one at a time.
// Returned beats are forwarded combinationally to a buffer sink.
// Ports:
//   aclk, aresetn        clock, synchronous active-low reset
//   axi                  AR/R channels (axi_dma_rd_if_if.master)
//   cfg_desc_addr_i/len_i, cfg_valid_i/cfg_ready_o   descriptor handshake
//   if_wr_push_o/data_o  beat to sink; if_wr_ready_i = room for a whole burst
//   st_last_o            one-cycle pulse after the descriptor completes
//   st_err_o             sticky error, cleared on next descriptor accept
// Build option: AXI_DMA_RD_BEAT_CHECK_EN adds per-burst beat counting; rlast
// on the wrong beat, or a missing rlast, sets st_err_o (the latter also forces
// the burst to end after BURST_LEN beats).
// ---------------------------------------------------------------------------
module axi_dma_rd_if #(
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int AXI_DATA_WIDTH  = 128,
    parameter int AXI_ID_WIDTH    = 1,
    parameter int AXI_ID          = 1,
    parameter int AXI_BURST_WIDTH = 6,
    parameter int LEN_WIDTH       = 20,
    parameter int DDR_WIDTH       = 27,
    parameter int BANK_WIDTH      = 3,
    parameter int SEC_WIDTH       = 2,
    parameter int BURST_LEN       = 8
) (
    input  logic                                    aclk,
    input  logic                                    aresetn,
    axi_dma_rd_if_if.master                         axi,
    input  logic [BANK_WIDTH+SEC_WIDTH+LEN_WIDTH-1:0] cfg_desc_addr_i,
    input  logic [LEN_WIDTH-1:0]                    cfg_desc_len_i,
    input  logic                                    cfg_valid_i,
    output logic                                    cfg_ready_o,
    output logic                                    if_wr_push_o,
    output logic [AXI_DATA_WIDTH-1:0]               if_wr_data_o,
    input  logic                                    if_wr_ready_i,
    output logic                                    st_last_o,
    output logic                                    st_err_o
);
    // Byte offset inside one burst: 8-byte addressing unit times BURST_LEN.
    localparam int SSUB = 3 + $clog2(BURST_LEN);
    localparam int IDXW = LEN_WIDTH - SSUB;
    // Field placement shared with the write-side master so identical
    // descriptors address identical DDR regions.
    localparam int BANK_LSB = DDR_WIDTH - BANK_WIDTH + 1;
    localparam int SEC_LSB  = BANK_LSB - 1 - SEC_WIDTH;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                state_q, state_d;
    logic                  arvalid_q, arvalid_d;
    logic                  st_last_q, st_last_d;
    logic                  st_err_q, st_err_d;
    logic [BANK_WIDTH-1:0] bank_q;
    logic [SEC_WIDTH-1:0]  sec_q;
    logic [IDXW-1:0]       idx_q;
    logic [IDXW-1:0]       rem_q;
    logic                  ld_desc, adv_burst, burst_end;
    logic                  id_ok, beat_acc;
    logic [IDXW-1:0]       cfg_cnt;
    logic [AXI_ADDR_WIDTH-1:0] araddr_w;
    logic                  unused_ok;

`ifdef AXI_DMA_RD_BEAT_CHECK_EN
    localparam int CNTW = $clog2(BURST_LEN) + 1;
    logic [CNTW-1:0] beat_cnt_q, beat_cnt_d;
    logic            final_beat;
`endif

    assign cfg_cnt   = cfg_desc_len_i[LEN_WIDTH-1:SSUB];
    assign unused_ok = ^{cfg_desc_addr_i[SSUB-1:0], cfg_desc_len_i[SSUB-1:0]};

    // Off-ID beats are neither acknowledged nor pushed.
    assign id_ok    = (axi.rid == AXI_ID_WIDTH'(AXI_ID));
    assign beat_acc = (state_q == DATA) && axi.rvalid && id_ok;

    always_comb begin
        araddr_w = '0;
        araddr_w[BANK_LSB +: BANK_WIDTH] = bank_q;
        araddr_w[SEC_LSB +: SEC_WIDTH]   = sec_q;
        araddr_w[SSUB +: IDXW]           = idx_q;
    end

    assign axi.arid    = AXI_ID_WIDTH'(AXI_ID);
    assign axi.arlen   = AXI_BURST_WIDTH'(BURST_LEN - 1);
    assign axi.araddr  = araddr_w;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = (state_q == DATA) && id_ok;

    assign cfg_ready_o  = (state_q == IDLE);
    assign if_wr_push_o = beat_acc;
    assign if_wr_data_o = axi.rdata;
    assign st_last_o    = st_last_q;
    assign st_err_o     = st_err_q;

    always_comb begin
        state_d   = state_q;
        arvalid_d = arvalid_q;
        st_last_d = 1'b0;
        st_err_d  = st_err_q;
        ld_desc   = 1'b0;
        adv_burst = 1'b0;
        burst_end = 1'b0;
`ifdef AXI_DMA_RD_BEAT_CHECK_EN
        beat_cnt_d = beat_cnt_q;
        final_beat = (beat_cnt_q == CNTW'(BURST_LEN - 1));
`endif
        case (state_q)
            IDLE: begin
                if (cfg_valid_i) begin
                    ld_desc  = 1'b1;
                    st_err_d = 1'b0;
                    if (cfg_cnt == '0) begin
                        st_last_d = 1'b1;
                    end else begin
                        state_d   = ADDR;
                        // arvalid is registered, so it can appear at the
                        // earliest in the first ADDR cycle.
                        arvalid_d = if_wr_ready_i;
                    end
                end
            end
            ADDR: begin
                if (!arvalid_q) begin
                    arvalid_d = if_wr_ready_i;
                end else if (axi.arready) begin
                    arvalid_d = 1'b0;
                    state_d   = DATA;
`ifdef AXI_DMA_RD_BEAT_CHECK_EN
                    beat_cnt_d = '0;
`endif
                end
            end
            DATA: begin
                if (beat_acc) begin
                    if (axi.rresp != 2'b00) st_err_d = 1'b1;
`ifdef AXI_DMA_RD_BEAT_CHECK_EN
                    beat_cnt_d = beat_cnt_q + CNTW'(1);
                    if (axi.rlast != final_beat) st_err_d = 1'b1;
                    burst_end = axi.rlast || final_beat;
`else
                    burst_end = axi.rlast;
`endif
                    if (burst_end) begin
                        if (rem_q == IDXW'(1)) begin
                            state_d   = IDLE;
                            st_last_d = 1'b1;
                        end else begin
                            adv_burst = 1'b1;
                            state_d   = ADDR;
                            arvalid_d = if_wr_ready_i;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            arvalid_q <= 1'b0;
            st_last_q <= 1'b0;
            st_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            arvalid_q <= arvalid_d;
            st_last_q <= st_last_d;
            st_err_q  <= st_err_d;
        end
    end

`ifdef AXI_DMA_RD_BEAT_CHECK_EN
    always_ff @(posedge aclk) begin
        if (!aresetn) beat_cnt_q <= '0;
        else          beat_cnt_q <= beat_cnt_d;
    end
`endif

    // Descriptor fields only matter while a transfer is active, so they are
    // left out of reset.
    always_ff @(posedge aclk) begin
        if (ld_desc) begin
            bank_q <= cfg_desc_addr_i[LEN_WIDTH+SEC_WIDTH +: BANK_WIDTH];
            sec_q  <= cfg_desc_addr_i[LEN_WIDTH +: SEC_WIDTH];
            idx_q  <= cfg_desc_addr_i[SSUB +: IDXW];
            rem_q  <= cfg_cnt;
        end else if (adv_burst) begin
            idx_q  <= idx_q + IDXW'(1);
            rem_q  <= rem_q - IDXW'(1);
        end
    end
endmodule

// File: tb/tb_axi_dma_rd_if.sv
module tb_axi_dma_rd_if;
    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [24:0]   cfg_desc_addr = '0;
    logic [19:0]   cfg_desc_len = '0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic          if_wr_push;
    logic [127:0]  if_wr_data;
    logic          if_wr_ready = 1'b1;
    logic          st_last;
    logic          st_err;

    int checks = 0;
    int failures = 0;
    int push_cnt = 0;

    axi_dma_rd_if_if #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(128),
                       .AXI_ID_WIDTH(1), .AXI_BURST_WIDTH(6)) axi ();

    axi_dma_rd_if dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .axi             (axi),
        .cfg_desc_addr_i (cfg_desc_addr),
        .cfg_desc_len_i  (cfg_desc_len),
        .cfg_valid_i     (cfg_valid),
        .cfg_ready_o     (cfg_ready),
        .if_wr_push_o    (if_wr_push),
        .if_wr_data_o    (if_wr_data),
        .if_wr_ready_i   (if_wr_ready),
        .st_last_o       (st_last),
        .st_err_o        (st_err)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) if (if_wr_push === 1'b1) push_cnt <= push_cnt + 1;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference address: bank at bit 25, section at bit 22, burst index
    // (wrapping over 14 bits) at bit 6.
    function automatic logic [31:0] exp_addr(input int bank, input int sec, input int idx);
        return 32'((bank << 25) | (sec << 22) | ((idx % 16384) << 6));
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic wait_arvalid(input string tag);
        int n;
        n = 0;
        while (axi.arvalid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_arvalid_wait"}, 128'(axi.arvalid), 128'(1));
    endtask

    // err_beat / foreign_beat are descriptor-global beat numbers (-1 = none);
    // the off-ID beat is inserted just before the numbered beat.
    task automatic run_desc(input int bank, input int sec, input int off, input int len,
                            input int stall0, input int gap1,
                            input int err_beat, input int foreign_beat);
        int nb, idx0, pushes0, g;
        bit exp_err;
        logic [127:0] d;
        nb = len >> 6;
        idx0 = off >> 6;
        exp_err = 1'b0;
        cfg_desc_addr = {3'(bank), 2'(sec), 20'(off)};
        cfg_desc_len  = 20'(len);
        cfg_valid = 1'b1;
        #1 check("cfg_ready_idle", 128'(cfg_ready), 128'(1));
        tick();
        cfg_valid = 1'b0;
        check("st_err_clear", 128'(st_err), 128'(0));
        pushes0 = push_cnt;
        if (nb == 0) begin
            check("zero_st_last", 128'(st_last), 128'(1));
            check("zero_no_ar", 128'(axi.arvalid), 128'(0));
            tick();
            check("zero_st_last_end", 128'(st_last), 128'(0));
            check("zero_no_ar2", 128'(axi.arvalid), 128'(0));
            return;
        end
        for (int k = 0; k < nb; k++) begin
            wait_arvalid("ar");
            check("araddr", 128'(axi.araddr), 128'(exp_addr(bank, sec, idx0 + k)));
            check("arlen", 128'(axi.arlen), 128'(7));
            check("arid", 128'(axi.arid), 128'(1));
            if (k == 0) begin
                for (int s = 0; s < stall0; s++) begin
                    tick();
                    check("ar_hold_valid", 128'(axi.arvalid), 128'(1));
                    check("ar_hold_addr", 128'(axi.araddr), 128'(exp_addr(bank, sec, idx0)));
                end
            end
            axi.arready = 1'b1;
            tick();
            axi.arready = 1'b0;
            check("ar_done", 128'(axi.arvalid), 128'(0));
            for (int b = 0; b < 8; b++) begin
                g = k * 8 + b;
                if (g == foreign_beat) begin
                    axi.rvalid = 1'b1; axi.rid = 1'b0; axi.rdata = rnd128();
                    axi.rresp = 2'd0; axi.rlast = 1'b0;
                    #1;
                    check("foreign_push", 128'(if_wr_push), 128'(0));
                    check("foreign_rready", 128'(axi.rready), 128'(0));
                    tick();
                end
                d = rnd128();
                axi.rvalid = 1'b1; axi.rid = 1'b1; axi.rdata = d;
                axi.rresp = (g == err_beat) ? 2'd2 : 2'd0;
                axi.rlast = (b == 7);
                if (b == 7 && k == 0 && gap1 > 0) if_wr_ready = 1'b0;
                #1;
                check("push", 128'(if_wr_push), 128'(1));
                check("push_data", if_wr_data, d);
                check("rready", 128'(axi.rready), 128'(1));
                tick();
                if (g == err_beat) begin
                    exp_err = 1'b1;
                    check("st_err_set", 128'(st_err), 128'(1));
                end
            end
            axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'd0;
            if (k == 0 && gap1 > 0) begin
                for (int s = 0; s < gap1; s++) begin
                    check("ar_blocked", 128'(axi.arvalid), 128'(0));
                    tick();
                end
                if_wr_ready = 1'b1;
            end
        end
        check("st_last", 128'(st_last), 128'(1));
        check("st_last_cfg_ready", 128'(cfg_ready), 128'(1));
        check("st_err_final", 128'(st_err), 128'(exp_err));
        check("push_count", 128'(push_cnt - pushes0), 128'(nb * 8));
        tick();
        check("st_last_pulse_end", 128'(st_last), 128'(0));
    endtask

    initial begin
        int bank, sec, off, len;
        axi.arready = 1'b0; axi.rid = 1'b0; axi.rdata = '0;
        axi.rresp = 2'd0; axi.rlast = 1'b0; axi.rvalid = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_cfg_ready", 128'(cfg_ready), 128'(1));
        check("rst_arvalid", 128'(axi.arvalid), 128'(0));
        check("rst_rready", 128'(axi.rready), 128'(0));
        check("rst_push", 128'(if_wr_push), 128'(0));
        check("rst_st_last", 128'(st_last), 128'(0));
        check("rst_st_err", 128'(st_err), 128'(0));
        aresetn = 1'b1;
        tick();

        // Directed: bank 2, sec 1, 4 bursts, AR stalled 5 cycles, sink not ready 10 cycles
        run_desc(2, 1, 0, 'h100, 5, 10, -1, -1);
        check("first_addr_const", 128'(exp_addr(2, 1, 0)), 128'(32'h0440_0000));

        // Error response on beat 3 plus an interleaved foreign-ID beat
        bank = $urandom_range(0, 7); sec = $urandom_range(0, 3);
        off = $urandom_range(0, 'hFFFFF);
        run_desc(bank, sec, off, 'h80, $urandom_range(0, 3), 0, 3, 12);

        // Burst index wrap at the top of the index range
        run_desc($urandom_range(0, 7), $urandom_range(0, 3), 'hFFFC0, 'hC0, 0, 0, -1, -1);

        // Zero-burst descriptor
        run_desc(1, 2, 'h40, 'h3F, 0, 0, -1, -1);

        // Random descriptors
        for (int r = 0; r < 3; r++) begin
            bank = $urandom_range(0, 7); sec = $urandom_range(0, 3);
            off = $urandom_range(0, 'hFFFFF);
            len = ($urandom_range(1, 3) << 6) | $urandom_range(0, 63);
            run_desc(bank, sec, off, len, $urandom_range(0, 4), 0, -1, -1);
        end

        // Reset in the middle of a burst
        cfg_desc_addr = {3'd1, 2'd0, 20'h0}; cfg_desc_len = 20'h80; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        wait_arvalid("mid_rst");
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        axi.rvalid = 1'b1; axi.rid = 1'b1; axi.rdata = rnd128(); axi.rresp = 2'd2; axi.rlast = 1'b0;
        tick();
        check("mid_rst_err_before", 128'(st_err), 128'(1));
        axi.rresp = 2'd0;
        aresetn = 1'b0;
        tick();
        check("mid_rst_rready", 128'(axi.rready), 128'(0));
        check("mid_rst_push", 128'(if_wr_push), 128'(0));
        check("mid_rst_cfg_ready", 128'(cfg_ready), 128'(1));
        check("mid_rst_arvalid", 128'(axi.arvalid), 128'(0));
        check("mid_rst_st_err", 128'(st_err), 128'(0));
        axi.rvalid = 1'b0;
        aresetn = 1'b1;
        tick();

`ifdef AXI_DMA_RD_BEAT_CHECK_EN
        // Early rlast on beat 6 ends the burst and flags an error
        cfg_desc_addr = {3'd3, 2'd2, 20'h0}; cfg_desc_len = 20'h40; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        wait_arvalid("beatchk");
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        for (int b = 0; b < 6; b++) begin
            axi.rvalid = 1'b1; axi.rid = 1'b1; axi.rdata = rnd128();
            axi.rresp = 2'd0; axi.rlast = (b == 5);
            tick();
        end
        axi.rvalid = 1'b0; axi.rlast = 1'b0;
        check("beatchk_st_last", 128'(st_last), 128'(1));
        check("beatchk_st_err", 128'(st_err), 128'(1));
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
